pwm_seq_ctrl: RTL and testbench



---
 rtl/pwm_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_pwm_seq_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl: steps pwm_core's compare register through a small table,
// holding each entry for a programmable number of PWM periods, and owns the
// core's enable/run/double-buffer-update controls. All outputs are registered.
module pwm_seq_ctrl #(
    parameter int         DEPTH    = 8,
    parameter logic [1:0] CMP_ADDR = 2'b01,
    localparam int        IW       = $clog2(DEPTH)
) (
    input  logic          mclk,
    input  logic          h_reset,
    input  logic          tbl_we,
    input  logic [IW-1:0] tbl_waddr,
    input  logic [31:0]   tbl_wdata,
    input  logic          seq_start,
    input  logic          seq_stop,
    input  logic [IW-1:0] seq_len,
    input  logic [7:0]    seq_repeat,
    input  logic          seq_loop,
    input  logic          pwm_ovflow,
    output logic          m_reg_cs,
    output logic          m_reg_wr,
    output logic [1:0]    m_reg_addr,
    output logic [31:0]   m_reg_wdata,
    output logic [3:0]    m_reg_be,
    input  logic          m_reg_ack,
    output logic          cfg_pwm_enb,
    output logic          cfg_pwm_run,
    output logic          cfg_pwm_dupdate,
    output logic          seq_busy,
    output logic [IW-1:0] seq_idx,
    output logic          seq_done
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, STOP} state_t;

    localparam logic [IW-1:0] IDX_ONE = 1;

    state_t        state, state_nxt;
    logic [31:0]   tbl [DEPTH];
    logic [7:0]    cnt, cnt_nxt;
    logic [IW-1:0] idx_nxt;
    logic          done_nxt;
    logic          cs_nxt;
    logic          run_nxt;
    logic [31:0]   wdata_nxt;

    // Step table; writable at any time, a loaded entry only changes its next load.
    always_ff @(posedge mclk or posedge h_reset) begin
        if (h_reset) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else if (tbl_we) begin
            tbl[tbl_waddr] <= tbl_wdata;
        end
    end

    // State register plus the registered copies of every output.
    always_ff @(posedge mclk or posedge h_reset) begin
        if (h_reset) begin
            state           <= IDLE;
            cnt             <= '0;
            seq_idx         <= '0;
            seq_done        <= 1'b0;
            seq_busy        <= 1'b0;
            m_reg_cs        <= 1'b0;
            m_reg_wr        <= 1'b0;
            m_reg_addr      <= 2'b00;
            m_reg_wdata     <= '0;
            m_reg_be        <= 4'h0;
            cfg_pwm_enb     <= 1'b0;
            cfg_pwm_run     <= 1'b0;
            cfg_pwm_dupdate <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            seq_idx         <= idx_nxt;
            seq_done        <= done_nxt;
            seq_busy        <= (state_nxt != IDLE);
            m_reg_cs        <= cs_nxt;
            m_reg_wr        <= cs_nxt;
            m_reg_addr      <= cs_nxt ? CMP_ADDR : 2'b00;
            m_reg_wdata     <= wdata_nxt;
            m_reg_be        <= cs_nxt ? 4'hF : 4'h0;
            cfg_pwm_enb     <= run_nxt;
            cfg_pwm_run     <= run_nxt;
            cfg_pwm_dupdate <= cs_nxt;
        end
    end

    // Next-state logic; seq_stop outranks start, ack and ovflow.
    always_comb begin
        state_nxt = state;
        idx_nxt   = seq_idx;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (seq_start && !seq_stop) begin
                    state_nxt = LOAD;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            LOAD: begin
                // An ack coinciding with stop still completes the bus cycle.
                if (m_reg_ack) begin
                    state_nxt = seq_stop ? IDLE : WAIT;
                    cnt_nxt   = '0;
                end else if (seq_stop) begin
                    state_nxt = STOP;
                end
            end
            WAIT: begin
                if (seq_stop) begin
                    state_nxt = IDLE;
                end else if (pwm_ovflow) begin
                    if (cnt != seq_repeat) begin
                        cnt_nxt = cnt + 8'd1;
                    end else if (seq_idx != seq_len) begin
                        idx_nxt   = seq_idx + IDX_ONE;
                        state_nxt = LOAD;
                    end else if (seq_loop) begin
                        idx_nxt   = '0;
                        state_nxt = LOAD;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            STOP: begin
                if (m_reg_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output next values: bus request spans LOAD/STOP, run latches on the first ack.
    always_comb begin
        cs_nxt    = (state_nxt == LOAD) || (state_nxt == STOP);
        wdata_nxt = m_reg_wdata;
        if (state_nxt == LOAD && state != LOAD) wdata_nxt = tbl[idx_nxt];
        run_nxt = cfg_pwm_run;
        if (state_nxt == IDLE)                        run_nxt = 1'b0;
        else if (state == LOAD && state_nxt == WAIT)  run_nxt = 1'b1;
    end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Bench for pwm_seq_ctrl: directed scenarios, a period-countdown reference
// model compared every cycle, a bus responder with programmable ack latency,
// and a write log checked against hand-computed sequences.
module tb_pwm_seq_ctrl;

    localparam int DEPTH = 8;
    localparam int IW    = 3;

    logic          mclk, h_reset;
    logic          tbl_we;
    logic [IW-1:0] tbl_waddr;
    logic [31:0]   tbl_wdata;
    logic          seq_start, seq_stop, seq_loop, pwm_ovflow;
    logic [IW-1:0] seq_len;
    logic [7:0]    seq_repeat;
    logic          m_reg_cs, m_reg_wr, m_reg_ack;
    logic [1:0]    m_reg_addr;
    logic [31:0]   m_reg_wdata;
    logic [3:0]    m_reg_be;
    logic          cfg_pwm_enb, cfg_pwm_run, cfg_pwm_dupdate;
    logic          seq_busy, seq_done;
    logic [IW-1:0] seq_idx;

    pwm_seq_ctrl #(.DEPTH(DEPTH), .CMP_ADDR(2'b01)) dut (
        .mclk(mclk), .h_reset(h_reset),
        .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
        .seq_start(seq_start), .seq_stop(seq_stop), .seq_len(seq_len),
        .seq_repeat(seq_repeat), .seq_loop(seq_loop), .pwm_ovflow(pwm_ovflow),
        .m_reg_cs(m_reg_cs), .m_reg_wr(m_reg_wr), .m_reg_addr(m_reg_addr),
        .m_reg_wdata(m_reg_wdata), .m_reg_be(m_reg_be), .m_reg_ack(m_reg_ack),
        .cfg_pwm_enb(cfg_pwm_enb), .cfg_pwm_run(cfg_pwm_run),
        .cfg_pwm_dupdate(cfg_pwm_dupdate), .seq_busy(seq_busy),
        .seq_idx(seq_idx), .seq_done(seq_done)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Bus responder: ack after ack_lat extra cs cycles, one cycle wide.
    int ack_lat = 1;
    int ack_w   = 0;
    always @(negedge mclk) begin
        if (h_reset) begin
            m_reg_ack = 1'b0; ack_w = 0;
        end else if (m_reg_ack) begin
            m_reg_ack = 1'b0; ack_w = 0;
        end else if (m_reg_cs) begin
            if (ack_w >= ack_lat) m_reg_ack = 1'b1;
            else ack_w++;
        end else begin
            ack_w = 0;
        end
    end

    // Log of completed bus writes.
    typedef struct packed {logic [1:0] a; logic [31:0] d; logic [3:0] be;} wr_t;
    wr_t wlog[$];
    always @(posedge mclk) begin
        if (!h_reset && m_reg_cs && m_reg_ack)
            wlog.push_back({m_reg_addr, m_reg_wdata, m_reg_be});
    end

    // Pulse / activity counters.
    int done_cnt = 0;
    int cs_cnt   = 0;
    always @(negedge mclk) begin
        if (seq_done) done_cnt++;
        if (m_reg_cs) cs_cnt++;
    end

    // Reference model: phase 0 idle, 1 bus write, 2 holding step, 3 draining
    // an aborted write. A step lasts seq_repeat+1 periods, counted down.
    int          ph, m_idx, m_left;
    logic [31:0] m_data;
    logic        m_run, m_done;
    logic [31:0] mt [DEPTH];

    always @(posedge mclk or posedge h_reset) begin
        if (h_reset) begin
            ph = 0; m_idx = 0; m_left = 0; m_data = '0; m_run = 1'b0; m_done = 1'b0;
            for (int i = 0; i < DEPTH; i++) mt[i] = '0;
        end else begin
            m_done = 1'b0;
            case (ph)
                0: if (seq_start && !seq_stop) begin
                       ph = 1; m_idx = 0; m_data = mt[0];
                   end
                1: if (seq_stop) begin
                       if (m_reg_ack) begin ph = 0; m_run = 1'b0; end
                       else ph = 3;
                   end else if (m_reg_ack) begin
                       ph = 2; m_left = int'(seq_repeat) + 1; m_run = 1'b1;
                   end
                2: if (seq_stop) begin
                       ph = 0; m_run = 1'b0;
                   end else if (pwm_ovflow) begin
                       m_left--;
                       if (m_left == 0) begin
                           if (m_idx < int'(seq_len)) begin
                               m_idx++; ph = 1; m_data = mt[m_idx];
                           end else if (seq_loop) begin
                               m_idx = 0; ph = 1; m_data = mt[0];
                           end else begin
                               ph = 0; m_done = 1'b1; m_run = 1'b0;
                           end
                       end
                   end
                default: if (m_reg_ack) begin ph = 0; m_run = 1'b0; end
            endcase
            if (tbl_we) mt[tbl_waddr] = tbl_wdata;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge mclk) begin
        logic exp_cs;
        exp_cs = (ph == 1) || (ph == 3);
        chk("cs",      32'(m_reg_cs),        32'(exp_cs));
        chk("wr",      32'(m_reg_wr),        32'(exp_cs));
        chk("dupdate", 32'(cfg_pwm_dupdate), 32'(exp_cs));
        chk("busy",    32'(seq_busy),        32'(ph != 0));
        chk("idx",     32'(seq_idx),         32'(m_idx));
        chk("done",    32'(seq_done),        32'(m_done));
        chk("run",     32'(cfg_pwm_run),     32'(m_run));
        chk("enb",     32'(cfg_pwm_enb),     32'(m_run));
        if (exp_cs) begin
            chk("addr",  32'(m_reg_addr), 32'h1);
            chk("be",    32'(m_reg_be),   32'hF);
            chk("wdata", m_reg_wdata,     m_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic wr_tbl(input int a, input logic [31:0] d);
        tbl_we = 1'b1; tbl_waddr = IW'(a); tbl_wdata = d;
        tick(1);
        tbl_we = 1'b0;
    endtask

    task automatic pulse_start();
        seq_start = 1'b1; tick(1); seq_start = 1'b0;
    endtask

    task automatic pulse_stop();
        seq_stop = 1'b1; tick(1); seq_stop = 1'b0;
    endtask

    task automatic pulse_ovf();
        pwm_ovflow = 1'b1; tick(1); pwm_ovflow = 1'b0;
    endtask

    initial begin
        int n0, d0, c0;
        h_reset = 1'b1; tbl_we = 1'b0; tbl_waddr = '0; tbl_wdata = '0;
        seq_start = 1'b0; seq_stop = 1'b0; seq_len = '0; seq_repeat = '0;
        seq_loop = 1'b0; pwm_ovflow = 1'b0;
        tick(3);
        chk("rst_cs",    32'(m_reg_cs),    32'h0);
        chk("rst_wdata", m_reg_wdata,      32'h0);
        chk("rst_be",    32'(m_reg_be),    32'h0);
        chk("rst_busy",  32'(seq_busy),    32'h0);
        chk("rst_run",   32'(cfg_pwm_run), 32'h0);
        h_reset = 1'b0;
        tick(1);
        wr_tbl(0, 32'h10); wr_tbl(1, 32'h20); wr_tbl(2, 32'h30);

        // Three-step run, one period per step.
        seq_len = 3'd2; seq_repeat = 8'd0; seq_loop = 1'b0; ack_lat = 1;
        n0 = wlog.size(); d0 = done_cnt;
        pulse_start();
        chk("t1_cs_lat",   32'(m_reg_cs),    32'h1);
        chk("t1_busy_lat", 32'(seq_busy),    32'h1);
        chk("t1_run_pre",  32'(cfg_pwm_run), 32'h0);
        tick(2);
        chk("t1_cs_after_ack",  32'(m_reg_cs),        32'h0);
        chk("t1_run_after_ack", 32'(cfg_pwm_run),     32'h1);
        chk("t1_dupd_wait",     32'(cfg_pwm_dupdate), 32'h0);
        for (int k = 0; k < 3; k++) begin tick(18); pulse_ovf(); end
        chk("t1_done_pulse", 32'(seq_done),    32'h1);
        chk("t1_busy_end",   32'(seq_busy),    32'h0);
        chk("t1_run_end",    32'(cfg_pwm_run), 32'h0);
        tick(1);
        chk("t1_done_once",  32'(done_cnt - d0), 32'd1);
        chk("t1_nwrites",    32'(wlog.size() - n0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_wdata", wlog[n0+i].d, 32'h10 * (i + 1));
            chk("t1_waddr", 32'(wlog[n0+i].a), 32'h1);
            chk("t1_wbe",   32'(wlog[n0+i].be), 32'hF);
        end

        // Single step held four periods, zero-wait ack.
        seq_len = 3'd0; seq_repeat = 8'd3; ack_lat = 0;
        n0 = wlog.size(); d0 = done_cnt;
        pulse_start();
        tick(5);
        for (int k = 1; k <= 4; k++) begin
            pulse_ovf();
            if (k < 4) chk("t2_busy_hold", 32'(seq_busy), 32'h1);
            else       chk("t2_done_4th",  32'(seq_done), 32'h1);
            tick(3);
        end
        chk("t2_done_once", 32'(done_cnt - d0), 32'd1);
        chk("t2_nwrites",   32'(wlog.size() - n0), 32'd1);
        chk("t2_wdata",     wlog[n0].d, 32'h10);

        // Looping two-entry sequence, stopped in WAIT.
        seq_len = 3'd1; seq_repeat = 8'd0; seq_loop = 1'b1; ack_lat = 1;
        n0 = wlog.size(); d0 = done_cnt;
        pulse_start();
        tick(10);
        repeat (6) begin pulse_ovf(); tick(10); end
        pulse_stop();
        chk("t3_busy_stop", 32'(seq_busy),    32'h0);
        chk("t3_run_stop",  32'(cfg_pwm_run), 32'h0);
        chk("t3_enb_stop",  32'(cfg_pwm_enb), 32'h0);
        tick(3);
        chk("t3_nwrites", 32'(wlog.size() - n0), 32'd7);
        for (int i = 0; i < 7; i++)
            chk("t3_wdata", wlog[n0+i].d, (i % 2 == 1) ? 32'h20 : 32'h10);
        chk("t3_no_done", 32'(done_cnt - d0), 32'd0);
        seq_loop = 1'b0;

        // Stop while the write is waiting on a slow ack.
        seq_len = 3'd0; ack_lat = 4;
        n0 = wlog.size(); d0 = done_cnt; c0 = cs_cnt;
        pulse_start();
        pulse_stop();
        tick(12);
        chk("t4_cs_cycles", 32'(cs_cnt - c0), 32'd5);
        chk("t4_busy",      32'(seq_busy), 32'h0);
        chk("t4_nwrites",   32'(wlog.size() - n0), 32'd1);
        tick(20);
        chk("t4_no_more",   32'(wlog.size() - n0), 32'd1);
        chk("t4_no_done",   32'(done_cnt - d0), 32'd0);

        // Start+stop together in IDLE, then start while busy.
        ack_lat = 1;
        n0 = wlog.size(); c0 = cs_cnt;
        seq_start = 1'b1; seq_stop = 1'b1; tick(1); seq_start = 1'b0; seq_stop = 1'b0;
        tick(5);
        chk("t5_idle_busy", 32'(seq_busy), 32'h0);
        chk("t5_idle_cs",   32'(cs_cnt - c0), 32'd0);
        seq_len = 3'd2; seq_repeat = 8'd0;
        pulse_start();
        tick(10);
        pulse_ovf();
        tick(10);
        chk("t5_idx_before", 32'(seq_idx), 32'd1);
        pulse_start();
        tick(2);
        chk("t5_idx_kept",  32'(seq_idx), 32'd1);
        chk("t5_busy_kept", 32'(seq_busy), 32'h1);
        chk("t5_nwrites",   32'(wlog.size() - n0), 32'd2);
        pulse_stop();
        tick(3);

        // Asynchronous reset in the middle of a second-step write.
        seq_len = 3'd1; ack_lat = 1;
        pulse_start();
        tick(6);
        ack_lat = 10;
        pulse_ovf();
        tick(2);
        chk("t6_pre_cs",  32'(m_reg_cs),    32'h1);
        chk("t6_pre_run", 32'(cfg_pwm_run), 32'h1);
        chk("t6_pre_idx", 32'(seq_idx),     32'd1);
        @(posedge mclk);
        #2 h_reset = 1'b1;
        #1;
        chk("t6_rst_cs",    32'(m_reg_cs),        32'h0);
        chk("t6_rst_wr",    32'(m_reg_wr),        32'h0);
        chk("t6_rst_addr",  32'(m_reg_addr),      32'h0);
        chk("t6_rst_wdata", m_reg_wdata,          32'h0);
        chk("t6_rst_be",    32'(m_reg_be),        32'h0);
        chk("t6_rst_enb",   32'(cfg_pwm_enb),     32'h0);
        chk("t6_rst_run",   32'(cfg_pwm_run),     32'h0);
        chk("t6_rst_dupd",  32'(cfg_pwm_dupdate), 32'h0);
        chk("t6_rst_busy",  32'(seq_busy),        32'h0);
        chk("t6_rst_idx",   32'(seq_idx),         32'h0);
        chk("t6_rst_done",  32'(seq_done),        32'h0);
        @(negedge mclk);
        h_reset = 1'b0;
        tick(2);
        ack_lat = 1; seq_len = 3'd0; seq_repeat = 8'd0;
        n0 = wlog.size();
        pulse_start();
        tick(6);
        chk("t6_nwrites", 32'(wlog.size() - n0), 32'd1);
        chk("t6_tbl_zero", wlog[wlog.size()-1].d, 32'h0);
        pulse_ovf();
        chk("t6_done", 32'(seq_done), 32'h1);
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
